// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI requester arbiter: FSM states and the per-slave
// config cache entry.
package spi_arb_pkg;
  localparam int SLAVE_W    = 3;
  localparam int CFG_W      = 4;
  localparam int NUM_SLAVES = 8;

  typedef enum logic [2:0] {
    IDLE, GRANT, CFG, CFG_GAP, SEND, BUSY, DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [CFG_W-1:0] cfg;
  } cfg_cache_t;

  // The slave mode register needs a rewrite when nothing is known about it
  // or it holds a different nibble.
  function automatic logic cache_miss(input cfg_cache_t e, input logic [CFG_W-1:0] cfg);
    return !e.valid || (e.cfg != cfg);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req strictly after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [2*N-1:0] dbl;

  always_comb begin
    dbl   = {req, req} >> (int'(ptr) + 1);
    grant = '0;
    idx   = '0;
    // Walk from the far end so the nearest requester after ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) idx = IW'((int'(ptr) + 1 + k) % N);
    end
    if (|req) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin front end that time-shares one spi_master byte engine, caching
// each slave's mode nibble so the mode register is only rewritten on change.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ*3-1:0]   i_req_slave,
  input  logic [NUM_REQ*4-1:0]   i_req_cfg,
  input  logic [NUM_REQ*8-1:0]   i_req_tx_byte,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [7:0]             o_rx_byte,
  output logic                   o_err,
  output logic                   o_config_slave,
  output logic [2:0]             o_slave_select,
  output logic [3:0]             o_config_data,
  output logic                   o_tx_data_valid,
  output logic [7:0]             o_tx_data_byte,
  input  logic                   i_tx_ready,
  input  logic                   i_rx_data_valid,
  input  logic [7:0]             i_rx_data_byte
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  cfg_cache_t         cache [NUM_SLAVES];
  logic [CW-1:0]      tmo_cnt;
  logic               expired, miss;
  logic [SLAVE_W-1:0] win_slave;
  logic [CFG_W-1:0]   win_cfg;
  logic [7:0]         win_byte;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    win_slave = '0;
    win_cfg   = '0;
    win_byte  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (arb_idx == IW'(r)) begin
        win_slave = i_req_slave[r*SLAVE_W +: SLAVE_W];
        win_cfg   = i_req_cfg[r*CFG_W +: CFG_W];
        win_byte  = i_req_tx_byte[r*8 +: 8];
      end
    end
  end

  assign miss    = cache_miss(cache[win_slave], win_cfg);
  assign expired = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|i_req && i_tx_ready) state_nxt = GRANT;
      GRANT:   if (!(|i_req))            state_nxt = IDLE;
               else if (miss)            state_nxt = CFG;
               else                      state_nxt = SEND;
      CFG:                               state_nxt = CFG_GAP;
      CFG_GAP:                           state_nxt = SEND;
      SEND:    if (i_tx_ready)           state_nxt = BUSY;
      BUSY:    if (i_rx_data_valid || expired) state_nxt = DONE;
      DONE:                              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Strobes are registered on the edge entering their state, so each is
  // exactly one cycle wide and aligned with CFG / first BUSY / DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      ptr             <= IW'(NUM_REQ - 1);
      tmo_cnt         <= '0;
      o_grant         <= '0;
      o_done          <= '0;
      o_rx_byte       <= '0;
      o_err           <= 1'b0;
      o_config_slave  <= 1'b0;
      o_slave_select  <= '0;
      o_config_data   <= '0;
      o_tx_data_valid <= 1'b0;
      o_tx_data_byte  <= '0;
      for (int s = 0; s < NUM_SLAVES; s++) cache[s] <= '0;
    end else begin
      state           <= state_nxt;
      o_config_slave  <= 1'b0;
      o_tx_data_valid <= 1'b0;
      o_done          <= '0;
      unique case (state)
        GRANT: if (|i_req) begin
          o_grant        <= arb_grant;
          ptr            <= arb_idx;
          o_slave_select <= win_slave;
          o_config_data  <= win_cfg;
          o_tx_data_byte <= win_byte;
          if (miss) begin
            o_config_slave   <= 1'b1;
            cache[win_slave] <= '{valid: 1'b1, cfg: win_cfg};
          end
        end
        SEND: begin
          tmo_cnt <= '0;
          if (i_tx_ready) o_tx_data_valid <= 1'b1;
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (i_rx_data_valid) begin
            o_rx_byte <= i_rx_data_byte;
            o_err     <= 1'b0;
            o_done    <= o_grant;
          end else if (expired) begin
            // A silent slave may have lost its mode; force a rewrite next time.
            o_rx_byte                   <= 8'h00;
            o_err                       <= 1'b1;
            o_done                      <= o_grant;
            cache[o_slave_select].valid <= 1'b0;
          end
        end
        DONE:    o_grant <= '0;
        default: ;
      endcase
    end
  end
endmodule
